// File: rtl/baud_tick_gen_if.sv
// Control and tick bundle between the baud tick generator and its UART users.
//   master: drives enable/restart/div_int/div_frac/div_load, receives the ticks
//   slave : the generator itself
//   enable      counting enable (state holds and ticks stay 0 when low)
//   restart     1-cycle phase realign pulse
//   div_int     new integer divisor (captured on div_load)
//   div_frac    new fractional divisor in 1/2^FRAC_W units
//   div_load    1-cycle capture strobe for div_int/div_frac
//   os_tick     oversample tick
//   bit_tick    bit-boundary tick (coincident with os_tick)
//   mid_tick    mid-bit tick (coincident with os_tick)
//   os_phase    oversample index within the current bit
//   cfg_pending loaded divisor waiting for the next period boundary
interface baud_tick_gen_if #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned OVS    = 16
);
  localparam int unsigned PH_W = $clog2(OVS);

  logic              enable;
  logic              restart;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              os_tick;
  logic              bit_tick;
  logic              mid_tick;
  logic [PH_W-1:0]   os_phase;
  logic              cfg_pending;

  modport master (
    output enable, restart, div_int, div_frac, div_load,
    input  os_tick, bit_tick, mid_tick, os_phase, cfg_pending
  );

  modport slave (
    input  enable, restart, div_int, div_frac, div_load,
    output os_tick, bit_tick, mid_tick, os_phase, cfg_pending
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator: divides clock by act_int + act_frac/2^FRAC_W
// to produce an oversample tick, plus bit-boundary and mid-bit ticks.
//   clock   system clock, rising edge
//   reset_n asynchronous active-low reset
//   bus     baud_tick_gen_if slave modport (controls in, registered ticks out)
module baud_tick_gen #(
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned FRAC_W   = 4,
  parameter int unsigned OVS      = 16,
  parameter int unsigned DEF_INT  = 325,
  parameter int unsigned DEF_FRAC = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  baud_tick_gen_if.slave    bus
);

  localparam int unsigned PH_W = $clog2(OVS);
  localparam logic [DIV_W-1:0]  DEF_INT_C  = DIV_W'(DEF_INT);
  localparam logic [FRAC_W-1:0] DEF_FRAC_C = FRAC_W'(DEF_FRAC);
  localparam logic [DIV_W-1:0]  MIN_INT    = DIV_W'(2);
  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0]   PH_MID     = PH_W'(OVS / 2);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic              os_q, os_d;
  logic              bit_q, bit_d;
  logic              mid_q, mid_d;

  logic [DIV_W:0]    term_val;
  logic              at_term;
  logic [DIV_W-1:0]  load_int;
  logic [FRAC_W-1:0] frac_eff;
  logic [FRAC_W:0]   acc_sum;

  // Period length is act_int, stretched by one clock when the last period carried.
  assign term_val = {1'b0, act_int_q} + (DIV_W+1)'(ext_q) - (DIV_W+1)'(1);
  assign at_term  = ({1'b0, cnt_q} == term_val);
  assign load_int = (bus.div_int < MIN_INT) ? MIN_INT : bus.div_int;
  // A deferred divisor governs the period that starts at this terminal, frac included.
  assign frac_eff = pend_q ? sh_frac_q : act_frac_q;

  // Next-state: restart beats enable and terminal; loads are resolved last.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ext_d      = ext_q;
    phase_d    = phase_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    os_d       = 1'b0;
    bit_d      = 1'b0;
    mid_d      = 1'b0;
    acc_sum    = '0;

    if (bus.restart) begin
      cnt_d   = '0;
      acc_d   = '0;
      ext_d   = 1'b0;
      phase_d = '0;
    end else if (bus.enable) begin
      if (at_term) begin
        cnt_d = '0;
        if (pend_q) begin
          act_int_d  = sh_int_q;
          act_frac_d = sh_frac_q;
          pend_d     = 1'b0;
        end
        acc_sum = {1'b0, acc_q} + {1'b0, frac_eff};
        acc_d   = acc_sum[FRAC_W-1:0];
        ext_d   = acc_sum[FRAC_W];
        phase_d = phase_q + PH_W'(1);
        os_d    = 1'b1;
        bit_d   = (phase_q == PH_LAST);
        mid_d   = (phase_q + PH_W'(1) == PH_MID);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    // Idle or realigning: nothing is mid-period, so apply the new divisor at once.
    if (bus.div_load) begin
      sh_int_d  = load_int;
      sh_frac_d = bus.div_frac;
      if (!bus.enable || bus.restart) begin
        act_int_d  = load_int;
        act_frac_d = bus.div_frac;
        pend_d     = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      ext_q      <= 1'b0;
      phase_q    <= '0;
      act_int_q  <= DEF_INT_C;
      act_frac_q <= DEF_FRAC_C;
      sh_int_q   <= DEF_INT_C;
      sh_frac_q  <= DEF_FRAC_C;
      pend_q     <= 1'b0;
      os_q       <= 1'b0;
      bit_q      <= 1'b0;
      mid_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ext_q      <= ext_d;
      phase_q    <= phase_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      os_q       <= os_d;
      bit_q      <= bit_d;
      mid_q      <= mid_d;
    end
  end

  assign bus.os_tick     = os_q;
  assign bus.bit_tick    = bit_q;
  assign bus.mid_tick    = mid_q;
  assign bus.os_phase    = phase_q;
  assign bus.cfg_pending = pend_q;

endmodule
